hex_entry_fsm: RTL and testbench
================================

Name: hex_entry_fsm

Overview:
Input-side counterpart of the scrolling hex display path. The user composes a 32-bit hex value on the five board buttons. A 16-bit display word (a 4-digit window) plus a cursor blink mask drive the existing 4-digit hex display driver. A committed value is presented with a one-cycle valid pulse to downstream logic.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles a raw button must hold before its debounced level changes (10 ms at 100 MHz)
BLINK_BITS, 24, width of the free-running blink counter; the counter MSB is the blink phase

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
btnU  in  1  raw button: increment digit
btnD  in  1  raw button: decrement digit
btnL  in  1  raw button: cursor left / upper window
btnR  in  1  raw button: cursor right / lower window
btnC  in  1  raw button: enter edit / commit
value_out  out  32  last committed value
value_valid  out  1  one-cycle pulse on commit
disp_word  out  16  four hex digits for the display driver
digit_blank  out  4  per-digit blank mask; bit i blanks display digit i
cursor  out  3  edited nibble index; 0 is the LSB nibble
editing  out  1  high in state EDIT

Behaviour:
- Reset values (async on rst_n low): value_out=0, value_valid=0, edit_val=0, cursor=0, window=0, state=IDLE, blink counter=0, all debouncers stable=0. Consequently disp_word=0, digit_blank=0, editing=0.
- Each button passes through a debouncer:
  - 2-FF synchroniser.
  - The stable level flips only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - A single-cycle press pulse is emitted on each stable 0->1 transition.
- Release and hold produce no further pulses.
- The FSM acts in the cycle after a pulse (registered).
- At most one action per cycle. Priority is C > U > D > L > R; lower-priority pulses in the same cycle are dropped, not queued.
- State IDLE:
  - disp_word = window ? value_out[31:16] : value_out[15:0].
  - L sets window=1; R sets window=0.
  - U and D are ignored.
  - C: edit_val<=value_out, cursor<=0, window<=0, state<=EDIT.
- State EDIT:
  - disp_word = window ? edit_val[31:16] : edit_val[15:0].
  - window always equals cursor[2], so the view scrolls automatically with the cursor.
  - U: nibble[cursor] <= nibble+1, mod 16 (F wraps to 0). Other nibbles are unchanged.
  - D: nibble[cursor] <= nibble-1, mod 16 (0 wraps to F).
  - L: cursor <= cursor+1, 7 wraps to 0.
  - R: cursor <= cursor-1, 0 wraps to 7.
  - C: value_out<=edit_val, value_valid=1 for exactly one cycle, state<=IDLE. window is kept as cursor[2].
- digit_blank:
  - Zero in IDLE.
  - In EDIT, bit cursor[1:0] = blink counter MSB; all other bits are 0.
  - The blink counter free-runs in all states.
- value_valid never asserts outside a commit.
- Back-to-back commits need two separate debounced presses.
- Reset mid-edit discards edit_val and returns to IDLE with value_out=0.
- A button still held while rst_n deasserts produces a pulse only after DEBOUNCE_CYCLES.

Decomposition:
- Package hex_entry_pkg holds:
  - state encoding: IDLE=1'b0, EDIT=1'b1
  - NUM_DIGITS=8 and CURSOR_W=3
  - action encoding: ACT_NONE, ACT_C, ACT_U, ACT_D, ACT_L, ACT_R
- One sub-module, btn_debounce, parameterised by DEBOUNCE_CYCLES, instantiated five times. Ports: clk, rst_n, btn_raw, btn_level, btn_pulse.
- The priority encoder, FSM, nibble arithmetic and output mux stay in hex_entry_fsm.

Test Plan (DEBOUNCE_CYCLES=4, BLINK_BITS=3):
1. Debounce. Glitch btnU high for 2 cycles -> no pulse. Then hold 10 cycles -> exactly one pulse, with the action applied 2 sync + 4 + 1 cycles after the first high cycle.
2. Basic entry and commit. Reset; C; U x3; L; D; C -> value_out=32'h0000_00F3, one value_valid pulse, editing=0.
3. Cursor wrap and window scroll. C, then R -> cursor=7, disp_word shows value_out[31:16]. U x2, L -> cursor=0, disp_word shows the low half. C -> value_out=32'h2000_00F3.
4. Nibble wrap. Cursor on a digit holding F: U -> 0. D -> F. Neighbouring nibbles unchanged.
5. Simultaneous and IDLE behaviour:
   - In IDLE, U or D -> no change.
   - In IDLE, L -> disp_word=value_out[31:16]; R -> low half.
   - C and U pulsed in the same cycle while in EDIT -> commit only; the value has no increment.
6. Blink and reset. In EDIT with cursor=5, digit_blank toggles between 4'b0010 and 0 every 4 cycles. Assert rst_n low mid-edit -> all outputs return to their reset values immediately (async), with no value_valid pulse.

Source files
------------

// File: rtl/hex_entry_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hex_entry_pkg
// Description : Shared types, constants and nibble helper for the hex entry
//               front end (state and action encodings, button indices).
// Revision    : 1.0 - initial release
// ============================================================================
package hex_entry_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EDIT = 1'b1
  } state_t;

  localparam int NUM_DIGITS = 8;
  localparam int CURSOR_W   = 3;
  localparam int VALUE_W    = NUM_DIGITS * 4;

  typedef enum logic [2:0] {
    ACT_NONE = 3'd0,
    ACT_C    = 3'd1,
    ACT_U    = 3'd2,
    ACT_D    = 3'd3,
    ACT_L    = 3'd4,
    ACT_R    = 3'd5
  } action_t;

  // Bit positions of the buttons inside the debouncer vectors
  localparam int BTN_R    = 0;
  localparam int BTN_L    = 1;
  localparam int BTN_D    = 2;
  localparam int BTN_U    = 3;
  localparam int BTN_C    = 4;
  localparam int NUM_BTNS = 5;

  // Step one nibble of a word up or down by one, modulo 16; other nibbles kept
  function automatic logic [VALUE_W-1:0] nibble_step(
    input logic [VALUE_W-1:0]  val,
    input logic [CURSOR_W-1:0] idx,
    input logic                up
  );
    logic [3:0]         nib;
    logic [VALUE_W-1:0] res;
    res = val;
    nib = val[{idx, 2'b00} +: 4];
    res[{idx, 2'b00} +: 4] = up ? (nib + 4'd1) : (nib - 4'd1);
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Two-flop synchroniser followed by a stability counter. The
//               debounced level changes only after the synchronised input has
//               disagreed with it for DEBOUNCE_CYCLES consecutive cycles; a
//               registered one-cycle pulse marks every 0->1 level change.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_pulse
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic             pulse;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous button into the clock domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Count consecutive disagreeing cycles; flip the level on the last one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= 1'b0;
      pulse  <= 1'b0;
      cnt    <= '0;
    end else if (sync2 == stable) begin
      cnt    <= '0;
      pulse  <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      stable <= sync2;
      cnt    <= '0;
      pulse  <= sync2;
    end else begin
      cnt    <= cnt + CNT_W'(1);
      pulse  <= 1'b0;
    end
  end

  assign btn_level = stable;
  assign btn_pulse = pulse;

endmodule
`default_nettype wire

// File: rtl/hex_entry_fsm.sv
`default_nettype none
// ============================================================================
// Module      : hex_entry_fsm
// Description : Five-button 32-bit hex value editor. Debounced presses are
//               prioritised into one action per cycle that drives an
//               IDLE/EDIT machine; a 4-digit window of the value and a blinking
//               cursor mask feed the hex display driver, and commits are
//               flagged with a one-cycle valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_entry_fsm
  import hex_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BLINK_BITS      = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                btnU,
  input  logic                btnD,
  input  logic                btnL,
  input  logic                btnR,
  input  logic                btnC,
  output logic [VALUE_W-1:0]  value_out,
  output logic                value_valid,
  output logic [15:0]         disp_word,
  output logic [3:0]          digit_blank,
  output logic [CURSOR_W-1:0] cursor,
  output logic                editing
);

  logic [NUM_BTNS-1:0]   btn_raw;
  logic [NUM_BTNS-1:0]   btn_pulse;
  logic [NUM_BTNS-1:0]   btn_level_unused;

  action_t               action;
  state_t                state;
  state_t                state_next;
  logic [VALUE_W-1:0]    edit_val;
  logic [VALUE_W-1:0]    edit_next;
  logic [VALUE_W-1:0]    value_next;
  logic [CURSOR_W-1:0]   cursor_next;
  logic                  window;
  logic                  window_next;
  logic                  valid_next;
  logic [BLINK_BITS-1:0] blink_cnt;
  logic [VALUE_W-1:0]    shown_val;

  assign btn_raw[BTN_R] = btnR;
  assign btn_raw[BTN_L] = btnL;
  assign btn_raw[BTN_D] = btnD;
  assign btn_raw[BTN_U] = btnU;
  assign btn_raw[BTN_C] = btnC;

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_raw   (btn_raw[g]),
      .btn_level (btn_level_unused[g]),
      .btn_pulse (btn_pulse[g])
    );
  end

  // Fixed-priority pick of one action; losing pulses are simply dropped
  always_comb begin
    action = ACT_NONE;
    if (btn_pulse[BTN_C])      action = ACT_C;
    else if (btn_pulse[BTN_U]) action = ACT_U;
    else if (btn_pulse[BTN_D]) action = ACT_D;
    else if (btn_pulse[BTN_L]) action = ACT_L;
    else if (btn_pulse[BTN_R]) action = ACT_R;
  end

  // Next-state and next-value logic for the edit machine
  always_comb begin
    state_next  = state;
    edit_next   = edit_val;
    value_next  = value_out;
    cursor_next = cursor;
    window_next = window;
    valid_next  = 1'b0;
    case (state)
      IDLE: begin
        case (action)
          ACT_C: begin
            edit_next   = value_out;
            cursor_next = '0;
            window_next = 1'b0;
            state_next  = EDIT;
          end
          ACT_L:   window_next = 1'b1;
          ACT_R:   window_next = 1'b0;
          default: ;
        endcase
      end
      EDIT: begin
        case (action)
          ACT_U: edit_next = nibble_step(edit_val, cursor, 1'b1);
          ACT_D: edit_next = nibble_step(edit_val, cursor, 1'b0);
          ACT_L: begin
            cursor_next = cursor + CURSOR_W'(1);
            window_next = cursor_next[CURSOR_W-1];
          end
          ACT_R: begin
            cursor_next = cursor - CURSOR_W'(1);
            window_next = cursor_next[CURSOR_W-1];
          end
          ACT_C: begin
            value_next  = edit_val;
            valid_next  = 1'b1;
            state_next  = IDLE;
          end
          default: ;
        endcase
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      edit_val    <= '0;
      value_out   <= '0;
      cursor      <= '0;
      window      <= 1'b0;
      value_valid <= 1'b0;
    end else begin
      state       <= state_next;
      edit_val    <= edit_next;
      value_out   <= value_next;
      cursor      <= cursor_next;
      window      <= window_next;
      value_valid <= valid_next;
    end
  end

  // Free-running blink phase generator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + BLINK_BITS'(1);
    end
  end

  // Display mux: edited value while editing, committed value otherwise
  always_comb begin
    editing     = (state == EDIT);
    shown_val   = editing ? edit_val : value_out;
    disp_word   = window ? shown_val[31:16] : shown_val[15:0];
    digit_blank = 4'b0000;
    if (editing) begin
      digit_blank[cursor[1:0]] = blink_cnt[BLINK_BITS-1];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hex_entry_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_hex_entry_fsm
// Description : Directed, table-driven bench for hex_entry_fsm with short
//               debounce and blink periods.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_entry_fsm;

  localparam int DEB   = 4;
  localparam int BLINK = 3;

  localparam logic [4:0] B_C = 5'b10000;
  localparam logic [4:0] B_U = 5'b01000;
  localparam logic [4:0] B_D = 5'b00100;
  localparam logic [4:0] B_L = 5'b00010;
  localparam logic [4:0] B_R = 5'b00001;

  typedef struct {
    logic [4:0]  btn;
    logic [31:0] val;
    logic [2:0]  cur;
    logic        ed;
    logic [15:0] disp;
    int          vcnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btnU = 1'b0, btnD = 1'b0, btnL = 1'b0, btnR = 1'b0, btnC = 1'b0;
  logic [31:0] value_out;
  logic        value_valid;
  logic [15:0] disp_word;
  logic [3:0]  digit_blank;
  logic [2:0]  cursor;
  logic        editing;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          vcnt     = 0;
  logic [2:0]  tb_blink;
  vec_t        vecs[28];

  hex_entry_fsm #(
    .DEBOUNCE_CYCLES(DEB),
    .BLINK_BITS     (BLINK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btnU       (btnU),
    .btnD       (btnD),
    .btnL       (btnL),
    .btnR       (btnR),
    .btnC       (btnC),
    .value_out  (value_out),
    .value_valid(value_valid),
    .disp_word  (disp_word),
    .digit_blank(digit_blank),
    .cursor     (cursor),
    .editing    (editing)
  );

  always #5 clk = ~clk;

  // Count every cycle value_valid is high (a stuck pulse inflates this)
  always @(posedge clk) if (value_valid) vcnt <= vcnt + 1;

  // Reference blink phase
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_blink <= 3'd0;
    else        tb_blink <= tb_blink + 3'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic press(input logic [4:0] b);
    {btnC, btnU, btnD, btnL, btnR} = b;
    repeat (8) @(negedge clk);
    {btnC, btnU, btnD, btnL, btnR} = 5'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      press(vecs[i].btn);
      check($sformatf("row%0d value_out", i), value_out, vecs[i].val);
      check($sformatf("row%0d cursor", i), {29'd0, cursor}, {29'd0, vecs[i].cur});
      check($sformatf("row%0d editing", i), {31'd0, editing}, {31'd0, vecs[i].ed});
      check($sformatf("row%0d disp_word", i), {16'd0, disp_word}, {16'd0, vecs[i].disp});
      check($sformatf("row%0d valid_count", i), vcnt, vecs[i].vcnt);
      if (!vecs[i].ed)
        check($sformatf("row%0d blank_idle", i), {28'd0, digit_blank}, 32'd0);
    end
  endtask

  initial begin
    int hit;
    int toggles;
    logic [3:0] prev_blank;

    //            btn      value          cur ed disp      vcnt
    vecs[0]  = '{B_C,       32'h0000_0000, 3'd0, 1'b1, 16'h0000, 0};
    vecs[1]  = '{B_U,       32'h0000_0000, 3'd0, 1'b1, 16'h0001, 0};
    vecs[2]  = '{B_U,       32'h0000_0000, 3'd0, 1'b1, 16'h0002, 0};
    vecs[3]  = '{B_U,       32'h0000_0000, 3'd0, 1'b1, 16'h0003, 0};
    vecs[4]  = '{B_L,       32'h0000_0000, 3'd1, 1'b1, 16'h0003, 0};
    vecs[5]  = '{B_D,       32'h0000_0000, 3'd1, 1'b1, 16'h00F3, 0};
    vecs[6]  = '{B_C,       32'h0000_00F3, 3'd1, 1'b0, 16'h00F3, 1};
    vecs[7]  = '{B_C,       32'h0000_00F3, 3'd0, 1'b1, 16'h00F3, 1};
    vecs[8]  = '{B_R,       32'h0000_00F3, 3'd7, 1'b1, 16'h0000, 1};
    vecs[9]  = '{B_U,       32'h0000_00F3, 3'd7, 1'b1, 16'h1000, 1};
    vecs[10] = '{B_U,       32'h0000_00F3, 3'd7, 1'b1, 16'h2000, 1};
    vecs[11] = '{B_L,       32'h0000_00F3, 3'd0, 1'b1, 16'h00F3, 1};
    vecs[12] = '{B_C,       32'h2000_00F3, 3'd0, 1'b0, 16'h00F3, 2};
    vecs[13] = '{B_U,       32'h2000_00F3, 3'd0, 1'b0, 16'h00F3, 2};
    vecs[14] = '{B_D,       32'h2000_00F3, 3'd0, 1'b0, 16'h00F3, 2};
    vecs[15] = '{B_L,       32'h2000_00F3, 3'd0, 1'b0, 16'h2000, 2};
    vecs[16] = '{B_R,       32'h2000_00F3, 3'd0, 1'b0, 16'h00F3, 2};
    vecs[17] = '{B_C,       32'h2000_00F3, 3'd0, 1'b1, 16'h00F3, 2};
    vecs[18] = '{B_L,       32'h2000_00F3, 3'd1, 1'b1, 16'h00F3, 2};
    vecs[19] = '{B_U,       32'h2000_00F3, 3'd1, 1'b1, 16'h0003, 2};
    vecs[20] = '{B_D,       32'h2000_00F3, 3'd1, 1'b1, 16'h00F3, 2};
    vecs[21] = '{B_L,       32'h2000_00F3, 3'd2, 1'b1, 16'h00F3, 2};
    vecs[22] = '{B_L,       32'h2000_00F3, 3'd3, 1'b1, 16'h00F3, 2};
    vecs[23] = '{B_L,       32'h2000_00F3, 3'd4, 1'b1, 16'h2000, 2};
    vecs[24] = '{B_L,       32'h2000_00F3, 3'd5, 1'b1, 16'h2000, 2};
    vecs[25] = '{B_C | B_U, 32'h2000_00F3, 3'd5, 1'b0, 16'h2000, 3};
    vecs[26] = '{B_C,       32'h2000_00F3, 3'd0, 1'b1, 16'h00F3, 3};
    vecs[27] = '{B_U,       32'h2000_00F3, 3'd0, 1'b1, 16'h00F4, 3};

    do_reset();
    check("reset value_out", value_out, 32'd0);
    check("reset value_valid", {31'd0, value_valid}, 32'd0);
    check("reset disp_word", {16'd0, disp_word}, 32'd0);
    check("reset digit_blank", {28'd0, digit_blank}, 32'd0);
    check("reset cursor", {29'd0, cursor}, 32'd0);
    check("reset editing", {31'd0, editing}, 32'd0);

    // Debounce: enter edit, then a 2-cycle glitch must be ignored
    press(B_C);
    check("deb enter editing", {31'd0, editing}, 32'd1);
    btnU = 1'b1;
    repeat (2) @(negedge clk);
    btnU = 1'b0;
    repeat (10) @(negedge clk);
    check("deb glitch ignored", {16'd0, disp_word}, 32'd0);
    // A held press acts exactly 2 + 4 + 1 edges after it is first sampled
    hit = 0;
    btnU = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (hit == 0 && disp_word != 16'd0) hit = i;
    end
    btnU = 1'b0;
    repeat (10) @(negedge clk);
    check("deb latency", hit, 7);
    check("deb single pulse", {16'd0, disp_word}, 32'd1);
    check("deb no commit", vcnt, 0);

    // Main directed sequence from a fresh reset
    do_reset();
    run_rows(0, 24);

    // Cursor 5 -> blink on display digit 1, toggling every 4 cycles
    toggles = 0;
    prev_blank = digit_blank;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check($sformatf("blink cyc%0d", i), {28'd0, digit_blank},
            {28'd0, (tb_blink[2] ? 4'b0010 : 4'b0000)});
      if (digit_blank != prev_blank) toggles++;
      prev_blank = digit_blank;
    end
    check("blink toggles", toggles, 4);

    run_rows(25, 27);

    // Asynchronous reset in the middle of an edit
    rst_n = 1'b0;
    #1;
    check("async value_out", value_out, 32'd0);
    check("async value_valid", {31'd0, value_valid}, 32'd0);
    check("async disp_word", {16'd0, disp_word}, 32'd0);
    check("async digit_blank", {28'd0, digit_blank}, 32'd0);
    check("async cursor", {29'd0, cursor}, 32'd0);
    check("async editing", {31'd0, editing}, 32'd0);
    repeat (3) @(negedge clk);
    check("async no valid pulse", vcnt, 3);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post reset idle", {31'd0, editing}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
